// File: rtl/timer_pkg.sv
// Shared definitions for the kitchen countdown timer: state codes, BCD digit
// limits and small digit-wrap helpers used by the mm:ss counter.
package timer_pkg;

  localparam int STATE_W = 2;
  localparam logic [3:0] BCD_UNIT_MAX = 4'd9;
  localparam logic [3:0] BCD_TENS_MAX = 4'd5;

  typedef enum logic [STATE_W-1:0] {
    ST_SET   = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_ALARM = 2'd3
  } timer_state_e;

  function automatic logic [3:0] bcd_wrap_inc(input logic [3:0] d, input logic [3:0] max_d);
    return (d >= max_d) ? 4'd0 : d + 4'd1;
  endfunction

  function automatic logic [3:0] bcd_wrap_dec(input logic [3:0] d, input logic [3:0] max_d);
    return (d == 4'd0) ? max_d : d - 4'd1;
  endfunction

endpackage

// File: rtl/bcd_mmss_counter.sv
// Four-digit mm:ss BCD register bank with clear, independent minute/second
// increments and a decrement with full borrow chain.
module bcd_mmss_counter
  import timer_pkg::*;
#(
  parameter int MAX_MIN10 = 5
) (
  input  logic       clk,
  input  logic       reset_p,
  input  logic       load_zero,
  input  logic       inc_min,
  input  logic       inc_sec,
  input  logic       dec,
  output logic [3:0] min10,
  output logic [3:0] min1,
  output logic [3:0] sec10,
  output logic [3:0] sec1,
  output logic       is_zero,
  output logic       will_be_zero
);

  localparam logic [3:0] MIN10_MAX = 4'(MAX_MIN10);

  logic [3:0] min10_r, min1_r, sec10_r, sec1_r;
  logic [3:0] min10_s, min1_s, sec10_s, sec1_s;
  logic       borrow0_s, borrow1_s, borrow2_s;

  assign min10 = min10_r;
  assign min1  = min1_r;
  assign sec10 = sec10_r;
  assign sec1  = sec1_r;

  assign is_zero      = (min10_r == 4'd0) && (min1_r == 4'd0) && (sec10_r == 4'd0) && (sec1_r == 4'd0);
  assign will_be_zero = dec && (min10_r == 4'd0) && (min1_r == 4'd0) && (sec10_r == 4'd0) && (sec1_r == 4'd1);

  assign borrow0_s = (sec1_r == 4'd0);
  assign borrow1_s = borrow0_s && (sec10_r == 4'd0);
  assign borrow2_s = borrow1_s && (min1_r == 4'd0);

  // Next digit values: clear beats decrement beats increments; decrement at 00:00 holds.
  always_comb begin
    min10_s = min10_r;
    min1_s  = min1_r;
    sec10_s = sec10_r;
    sec1_s  = sec1_r;
    if (load_zero) begin
      min10_s = 4'd0;
      min1_s  = 4'd0;
      sec10_s = 4'd0;
      sec1_s  = 4'd0;
    end else if (dec && !is_zero) begin
      sec1_s  = bcd_wrap_dec(sec1_r, BCD_UNIT_MAX);
      sec10_s = borrow0_s ? bcd_wrap_dec(sec10_r, BCD_TENS_MAX) : sec10_r;
      min1_s  = borrow1_s ? bcd_wrap_dec(min1_r, BCD_UNIT_MAX) : min1_r;
      min10_s = borrow2_s ? bcd_wrap_dec(min10_r, MIN10_MAX) : min10_r;
    end else begin
      sec1_s  = inc_sec ? bcd_wrap_inc(sec1_r, BCD_UNIT_MAX) : sec1_r;
      sec10_s = (inc_sec && (sec1_r == BCD_UNIT_MAX)) ? bcd_wrap_inc(sec10_r, BCD_TENS_MAX) : sec10_r;
      min1_s  = inc_min ? bcd_wrap_inc(min1_r, BCD_UNIT_MAX) : min1_r;
      min10_s = (inc_min && (min1_r == BCD_UNIT_MAX)) ? bcd_wrap_inc(min10_r, MIN10_MAX) : min10_r;
    end
  end

  // Digit registers.
  always_ff @(posedge clk) begin
    if (reset_p) begin
      min10_r <= 4'd0;
      min1_r  <= 4'd0;
      sec10_r <= 4'd0;
      sec1_r  <= 4'd0;
    end else begin
      min10_r <= min10_s;
      min1_r  <= min1_s;
      sec10_r <= sec10_s;
      sec1_r  <= sec1_s;
    end
  end

endmodule

// File: rtl/countdown_timer_ctrl.sv
// Kitchen-timer controller: SET/RUN/PAUSE/ALARM sequencing over a BCD mm:ss
// countdown, with an auto-expiring alarm.
module countdown_timer_ctrl
  import timer_pkg::*;
#(
  parameter int ALARM_SEC = 10,
  parameter int MAX_MIN10 = 5
) (
  input  logic               clk,
  input  logic               reset_p,
  input  logic               clk_sec,
  input  logic               btn_start,
  input  logic               btn_clear,
  input  logic               btn_inc_min,
  input  logic               btn_inc_sec,
  output logic [3:0]         min10,
  output logic [3:0]         min1,
  output logic [3:0]         sec10,
  output logic [3:0]         sec1,
  output logic               running,
  output logic               alarm,
  output logic [STATE_W-1:0] state
);

  localparam logic [5:0] ALARM_LAST = 6'(ALARM_SEC - 1);

  timer_state_e state_r, state_nx_s;
  logic [5:0]   alarm_cnt_r, alarm_cnt_nx_s;
  logic         running_r, alarm_r;
  logic         load_zero_s, dec_s, inc_min_s, inc_sec_s;
  logic         is_zero_s, will_be_zero_s;

  bcd_mmss_counter #(.MAX_MIN10(MAX_MIN10)) u_counter (
    .clk         (clk),
    .reset_p     (reset_p),
    .load_zero   (load_zero_s),
    .inc_min     (inc_min_s),
    .inc_sec     (inc_sec_s),
    .dec         (dec_s),
    .min10       (min10),
    .min1        (min1),
    .sec10       (sec10),
    .sec1        (sec1),
    .is_zero     (is_zero_s),
    .will_be_zero(will_be_zero_s)
  );

  assign state   = state_r;
  assign running = running_r;
  assign alarm   = alarm_r;

  // Next state, alarm counter and counter commands; clear > start > clk_sec > inc.
  always_comb begin
    state_nx_s     = state_r;
    alarm_cnt_nx_s = alarm_cnt_r;
    load_zero_s    = 1'b0;
    dec_s          = 1'b0;
    inc_min_s      = 1'b0;
    inc_sec_s      = 1'b0;
    case (state_r)
      ST_SET: begin
        if (btn_clear) begin
          load_zero_s = 1'b1;
        end else if (btn_start) begin
          state_nx_s = is_zero_s ? ST_SET : ST_RUN;
        end else begin
          inc_min_s = btn_inc_min;
          inc_sec_s = btn_inc_sec;
        end
      end
      ST_RUN: begin
        if (btn_clear) begin
          load_zero_s = 1'b1;
          state_nx_s  = ST_SET;
        end else begin
          // A tick coinciding with start still decrements; reaching zero beats pause.
          dec_s = clk_sec;
          if (will_be_zero_s) begin
            state_nx_s     = ST_ALARM;
            alarm_cnt_nx_s = 6'd0;
          end else if (btn_start) begin
            state_nx_s = ST_PAUSE;
          end else begin
            state_nx_s = ST_RUN;
          end
        end
      end
      ST_PAUSE: begin
        if (btn_clear) begin
          load_zero_s = 1'b1;
          state_nx_s  = ST_SET;
        end else if (btn_start) begin
          state_nx_s = ST_RUN;
        end else begin
          state_nx_s = ST_PAUSE;
        end
      end
      ST_ALARM: begin
        if (btn_clear || btn_start) begin
          load_zero_s    = 1'b1;
          state_nx_s     = ST_SET;
          alarm_cnt_nx_s = 6'd0;
        end else if (clk_sec) begin
          if (alarm_cnt_r >= ALARM_LAST) begin
            state_nx_s     = ST_SET;
            alarm_cnt_nx_s = 6'd0;
          end else begin
            alarm_cnt_nx_s = alarm_cnt_r + 6'd1;
          end
        end else begin
          state_nx_s = ST_ALARM;
        end
      end
      default: begin
        state_nx_s     = ST_SET;
        alarm_cnt_nx_s = 6'd0;
        load_zero_s    = 1'b1;
      end
    endcase
  end

  // State, alarm counter and registered status flags.
  always_ff @(posedge clk) begin
    if (reset_p) begin
      state_r     <= ST_SET;
      alarm_cnt_r <= 6'd0;
      running_r   <= 1'b0;
      alarm_r     <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      alarm_cnt_r <= alarm_cnt_nx_s;
      running_r   <= (state_nx_s == ST_RUN);
      alarm_r     <= (state_nx_s == ST_ALARM);
    end
  end

endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// Self-checking bench: directed scenarios plus randomized button/tick traffic,
// compared every cycle against a seconds-count reference model.
module tb_countdown_timer_ctrl;

  localparam int ALARM_SEC = 10;

  logic clk = 1'b0;
  always #4 clk = ~clk;

  logic       reset_p, clk_sec, btn_start, btn_clear, btn_inc_min, btn_inc_sec;
  logic [3:0] min10, min1, sec10, sec1;
  logic       running, alarm;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  // reference model: mode 0=SET 1=RUN 2=PAUSE 3=ALARM, value kept as minutes/seconds integers
  int m_mode = 0, m_min = 0, m_sec = 0, m_acnt = 0;

  countdown_timer_ctrl #(.ALARM_SEC(ALARM_SEC), .MAX_MIN10(5)) dut (
    .clk        (clk),
    .reset_p    (reset_p),
    .clk_sec    (clk_sec),
    .btn_start  (btn_start),
    .btn_clear  (btn_clear),
    .btn_inc_min(btn_inc_min),
    .btn_inc_sec(btn_inc_sec),
    .min10      (min10),
    .min1       (min1),
    .sec10      (sec10),
    .sec1       (sec1),
    .running    (running),
    .alarm      (alarm),
    .state      (state)
  );

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] bcd_of(input int mi, input int se);
    return {4'(mi / 10), 4'(mi % 10), 4'(se / 10), 4'(se % 10)};
  endfunction

  task automatic model_step(input bit rst, input bit sec, input bit st, input bit clr,
                            input bit im, input bit is);
    int t;
    if (rst) begin
      m_mode = 0; m_min = 0; m_sec = 0; m_acnt = 0;
    end else begin
      case (m_mode)
        0: begin
          if (clr) begin
            m_min = 0; m_sec = 0;
          end else if (st) begin
            if (m_min * 60 + m_sec > 0) m_mode = 1;
          end else begin
            if (im) m_min = (m_min + 1) % 60;
            if (is) m_sec = (m_sec + 1) % 60;
          end
        end
        1: begin
          if (clr) begin
            m_mode = 0; m_min = 0; m_sec = 0;
          end else if (sec) begin
            t = m_min * 60 + m_sec - 1;
            m_min = t / 60; m_sec = t % 60;
            if (t == 0) begin
              m_mode = 3; m_acnt = 0;
            end else if (st) begin
              m_mode = 2;
            end
          end else if (st) begin
            m_mode = 2;
          end
        end
        2: begin
          if (clr) begin
            m_mode = 0; m_min = 0; m_sec = 0;
          end else if (st) begin
            m_mode = 1;
          end
        end
        3: begin
          if (clr || st) begin
            m_mode = 0; m_acnt = 0;
          end else if (sec) begin
            m_acnt++;
            if (m_acnt == ALARM_SEC) begin
              m_mode = 0; m_acnt = 0;
            end
          end
        end
        default: m_mode = 0;
      endcase
    end
  endtask

  task automatic cycle(input bit rst, input bit sec, input bit st, input bit clr,
                       input bit im, input bit is);
    reset_p = rst; clk_sec = sec; btn_start = st; btn_clear = clr;
    btn_inc_min = im; btn_inc_sec = is;
    model_step(rst, sec, st, clr, im, is);
    @(posedge clk);
    #1;
    reset_p = 1'b0; clk_sec = 1'b0; btn_start = 1'b0; btn_clear = 1'b0;
    btn_inc_min = 1'b0; btn_inc_sec = 1'b0;
    check_eq("state", {14'd0, state}, 16'(m_mode));
    check_eq("digits", {min10, min1, sec10, sec1}, bcd_of(m_min, m_sec));
    check_eq("running", {15'd0, running}, 16'(m_mode == 1));
    check_eq("alarm", {15'd0, alarm}, 16'(m_mode == 3));
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic set_value(input int mi, input int se);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (mi) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (se) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    reset_p = 1'b1; clk_sec = 1'b0; btn_start = 1'b0; btn_clear = 1'b0;
    btn_inc_min = 1'b0; btn_inc_sec = 1'b0;
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("reset_digits", {min10, min1, sec10, sec1}, 16'h0000);

    // set 03:05
    set_value(3, 5);
    check_eq("tp_set_0305", {min10, min1, sec10, sec1}, 16'h0305);
    check_eq("tp_set_state", {14'd0, state}, 16'd0);

    // 00:03 counts down into alarm, alarm expires after ALARM_SEC ticks
    set_value(0, 3);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (3) begin
      idle(2);
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    check_eq("tp_alarm_on", {15'd0, alarm}, 16'd1);
    check_eq("tp_alarm_state", {14'd0, state}, 16'd3);
    repeat (ALARM_SEC) begin
      idle(1);
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    check_eq("tp_alarm_expired", {14'd0, state}, 16'd0);
    check_eq("tp_alarm_off", {15'd0, alarm}, 16'd0);

    // 10:00 run, pause holds, resume
    set_value(10, 0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("tp_borrow_0959", {min10, min1, sec10, sec1}, 16'h0959);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (5) cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("tp_pause_hold", {min10, min1, sec10, sec1}, 16'h0959);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("tp_resume_0958", {min10, min1, sec10, sec1}, 16'h0958);
    check_eq("tp_resume_state", {14'd0, state}, 16'd1);

    // seconds wrap without carry, start ignored at 00:00
    set_value(0, 60);
    check_eq("tp_sec_wrap", {min10, min1, sec10, sec1}, 16'h0000);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("tp_start_at_zero", {14'd0, state}, 16'd0);
    set_value(60, 0);
    check_eq("tp_min_wrap", {min10, min1, sec10, sec1}, 16'h0000);

    // 00:01 with tick + start together: alarm wins; clear cancels alarm
    set_value(0, 1);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("tp_alarm_beats_pause", {14'd0, state}, 16'd3);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("tp_clear_alarm", {15'd0, alarm}, 16'd0);

    // reset coincident with tick at 05:30
    set_value(5, 30);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("tp_reset_run", {min10, min1, sec10, sec1}, 16'h0000);
    check_eq("tp_reset_state", {14'd0, state}, 16'd0);

    // randomized traffic from small preset values
    for (int blk = 0; blk < 15; blk++) begin
      set_value($urandom_range(0, 1), $urandom_range(1, 20));
      cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 200; i++) begin
        cycle($urandom_range(0, 499) == 0, $urandom_range(0, 2) == 0,
              $urandom_range(0, 19) == 0, $urandom_range(0, 59) == 0,
              $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
